// File: rtl/bcs_serial_cmp_ctrl.sv
// Bit-serial compare controller driving one external 1-bit comparator slice.
// Optional macro BCS_CMP_SIGNED_EN selects two's-complement compare.
module bcs_serial_cmp_ctrl #(
    parameter int WIDTH = 8,
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_e,
    output logic             slice_g,
    input  logic             slice_e_in,
    input  logic             slice_g_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             res_eq,
    output logic             res_gt,
    output logic             res_lt,
    output logic             slice_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             e_acc;
    logic             g_acc;
    logic [CNT_W-1:0] cnt;
    logic             run;
    logic             done;
    logic             last;

    assign run  = (state == RUN);
    assign done = (state == DONE);
    assign last = (cnt == CNT_W'(WIDTH - 1));

    // Control: accept operands, run WIDTH slice cycles, hold result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state <= RUN;
                RUN:     if (last) state <= DONE;
                DONE:    if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: operand shifters, cascade accumulators and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            e_acc <= 1'b1;
            g_acc <= 1'b0;
            cnt   <= '0;
        end else if (state == IDLE && in_valid) begin
            a_sh  <= op_a;
            b_sh  <= op_b;
            e_acc <= 1'b1;
            g_acc <= 1'b0;
            cnt   <= '0;
        end else if (run) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            e_acc <= slice_e_in;
            g_acc <= slice_g_in;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Sticky flag for an impossible slice answer (equal and greater together)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slice_err <= 1'b0;
        end else if (run && slice_e_in && slice_g_in) begin
            slice_err <= 1'b1;
        end
    end

    // Slice drive: quiet outside RUN; sign bits swapped on the MSB when signed
    always_comb begin
        slice_a = 1'b0;
        slice_b = 1'b0;
        slice_e = 1'b0;
        slice_g = 1'b0;
        if (run) begin
`ifdef BCS_CMP_SIGNED_EN
            slice_a = last ? b_sh[0] : a_sh[0];
            slice_b = last ? a_sh[0] : b_sh[0];
`else
            slice_a = a_sh[0];
            slice_b = b_sh[0];
`endif
            slice_e = e_acc;
            slice_g = g_acc;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = done;
    assign res_eq    = done & e_acc;
    assign res_gt    = done & g_acc;
    assign res_lt    = done & ~e_acc & ~g_acc;

endmodule

// File: tb/tb_bcs_serial_cmp_ctrl.sv
// Self-checking bench for bcs_serial_cmp_ctrl with a behavioural slice model.
// Directed vector table plus sequences for back-pressure, reset and faults.
module tb_bcs_serial_cmp_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         slice_a;
    logic         slice_b;
    logic         slice_e;
    logic         slice_g;
    logic         s_e1;
    logic         s_g1;
    logic         out_valid;
    logic         out_ready;
    logic         res_eq;
    logic         res_gt;
    logic         res_lt;
    logic         slice_err;

    logic fault_en;
    logic fault_now;
    logic err_m;
    int   n_chk;
    int   n_err;

    always #5 clk = ~clk;

    bcs_serial_cmp_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_e    (slice_e),
        .slice_g    (slice_g),
        .slice_e_in (s_e1),
        .slice_g_in (s_g1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .res_eq     (res_eq),
        .res_gt     (res_gt),
        .res_lt     (res_lt),
        .slice_err  (slice_err)
    );

    // Behavioural comparator slice with an injectable e1=g1=1 fault
    always_comb begin
        if (fault_now) begin
            s_e1 = 1'b1;
            s_g1 = 1'b1;
        end else begin
            s_e1 = slice_e & (slice_a ~^ slice_b);
            s_g1 = (slice_a & ~slice_b) | ((slice_a ~^ slice_b) & slice_g);
        end
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         eq;
        logic         gt;
        logic         lt;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_compare(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic eq, input logic gt, input logic lt);
        logic e_m;
        logic g_m;
        logic ea;
        logic eb;
        logic seen;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e_m = 1'b1;
        g_m = 1'b0;
        seen = 1'b0;
        for (int k = 0; k <= W && !seen; k++) begin
            @(negedge clk);
            chk("slice_err", slice_err, err_m);
            if (k < W) begin
                ea = a[k];
                eb = b[k];
`ifdef BCS_CMP_SIGNED_EN
                if (k == W - 1) begin
                    ea = b[k];
                    eb = a[k];
                end
`endif
                chk("run_out_valid", out_valid, 0);
                chk("run_in_ready", in_ready, 0);
                chk("run_slice_a", slice_a, ea);
                chk("run_slice_b", slice_b, eb);
                chk("run_slice_e", slice_e, e_m);
                chk("run_slice_g", slice_g, g_m);
                fault_now = fault_en && (k == 2);
                if (fault_now) begin
                    e_m = 1'b1;
                    g_m = 1'b1;
                    err_m = 1'b1;
                end else begin
                    g_m = (ea & ~eb) | ((ea ~^ eb) & g_m);
                    e_m = e_m & (ea ~^ eb);
                end
            end else begin
                fault_now = 1'b0;
                chk("latency_out_valid", out_valid, 1);
                if (out_valid) begin
                    seen = 1'b1;
                    chk("res_eq", res_eq, eq);
                    chk("res_gt", res_gt, gt);
                    chk("res_lt", res_lt, lt);
                    chk("done_slice_quiet",
                        {slice_a, slice_b, slice_e, slice_g}, 0);
                end
            end
        end
        fault_now = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_res", {res_eq, res_gt, res_lt}, 0);
    endtask

    task automatic wait_valid(input string nm);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3 * W && !ok; i++) begin
            @(negedge clk);
            ok = out_valid;
        end
        chk(nm, ok, 1);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op_a = '0;
        op_b = '0;
        fault_en = 1'b0;
        fault_now = 1'b0;
        err_m = 1'b0;

        vecs[0] = '{8'hA5, 8'hA5, 1, 0, 0};
        vecs[1] = '{8'h02, 8'h03, 0, 0, 1};
        vecs[2] = '{8'h00, 8'h00, 1, 0, 0};
        vecs[3] = '{8'h7E, 8'h7F, 0, 0, 1};
        vecs[4] = '{8'hC3, 8'hC2, 0, 1, 0};
`ifdef BCS_CMP_SIGNED_EN
        vecs[5] = '{8'h80, 8'h7F, 0, 0, 1};
        vecs[6] = '{8'hFF, 8'h00, 0, 0, 1};
        vecs[7] = '{8'h00, 8'hFF, 0, 1, 0};
        vecs[8] = '{8'h01, 8'h80, 0, 1, 0};
`else
        vecs[5] = '{8'h80, 8'h7F, 0, 1, 0};
        vecs[6] = '{8'hFF, 8'h00, 0, 1, 0};
        vecs[7] = '{8'h00, 8'hFF, 0, 0, 1};
        vecs[8] = '{8'h01, 8'h80, 0, 0, 1};
`endif

        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_res", {res_eq, res_gt, res_lt}, 0);
        chk("rst_slice", {slice_a, slice_b, slice_e, slice_g}, 0);
        chk("rst_slice_err", slice_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 9; v++) begin
            do_compare(vecs[v].a, vecs[v].b,
                       vecs[v].eq, vecs[v].gt, vecs[v].lt);
        end

        // Back-pressure with in_valid held high throughout
        @(negedge clk);
        in_valid = 1'b1;
        op_a = 8'h02;
        op_b = 8'h03;
        @(posedge clk);
        #1;
        op_a = 8'h09;
        wait_valid("bp_wait_valid");
        chk("bp_first_lt", {res_eq, res_gt, res_lt}, 3'b001);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_res", {res_eq, res_gt, res_lt}, 3'b001);
            chk("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_in_ready", in_ready, 1);
        chk("bp_idle_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_accept", in_ready, 0);
        wait_valid("bp_wait_second");
        chk("bp_second_gt", {res_eq, res_gt, res_lt}, 3'b010);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of RUN at cnt = 3
        @(negedge clk);
        in_valid = 1'b1;
        op_a = 8'h33;
        op_b = 8'h44;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_slice", {slice_a, slice_b, slice_e, slice_g}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            logic any_valid;
            any_valid = 1'b0;
            for (int i = 0; i < 2 * W; i++) begin
                @(negedge clk);
                any_valid = any_valid | out_valid;
            end
            chk("mid_rst_no_result", any_valid, 0);
        end
        do_compare(8'h10, 8'h01, 0, 1, 0);

        // Faulty slice on bit 2: sticky error, results still delivered
        fault_en = 1'b1;
        do_compare(8'h05, 8'h05, 1, 1, 0);
        fault_en = 1'b0;
        chk("fault_sticky", slice_err, 1);
        do_compare(8'h03, 8'h01, 0, 1, 0);
        chk("fault_still_set", slice_err, 1);
        @(negedge clk);
        rst_n = 1'b0;
        err_m = 1'b0;
        #1;
        chk("fault_cleared", slice_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_compare(8'h04, 8'h07, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
